// File: rtl/tp_mon_pkg.sv
// Shared defaults and width helpers for the test-point event monitor.
package tp_mon_pkg;

  localparam int DEF_NCH     = 8;
  localparam int DEF_STRETCH = 16;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_WIN     = 40000;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tp_mon_chan.sv
// One event channel: edge detect, retriggerable stretch, toggle,
// saturating total and per-window counts with a snapshot-on-wrap rate register.
module tp_mon_chan
  import tp_mon_pkg::*;
#(
  parameter int STRETCH = DEF_STRETCH,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_in,
  input  logic             clr,
  input  logic             snap,
  output logic             tp_stretch,
  output logic             tp_toggle,
  output logic [CNT_W-1:0] total,
  output logic [CNT_W-1:0] rate
);

  localparam int               SW           = idx_width(STRETCH + 1);
  localparam logic [SW-1:0]    STRETCH_LOAD = SW'(STRETCH);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic             evt_q;
  logic             evt_qq;
  logic             rise;
  logic             cnt_evt;
  logic [SW-1:0]    stretch_cnt;
  logic [CNT_W-1:0] win_cnt;

  assign rise = evt_q & ~evt_qq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q   <= 1'b0;
      evt_qq  <= 1'b0;
      cnt_evt <= 1'b0;
    end else begin
      evt_q   <= evt_in;
      evt_qq  <= evt_q;
      cnt_evt <= rise;
    end
  end

  // Reload on every rise so back-to-back events merge into one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stretch_cnt <= '0;
      tp_stretch  <= 1'b0;
    end else begin
      if (rise) begin
        stretch_cnt <= STRETCH_LOAD;
      end else if (stretch_cnt != '0) begin
        stretch_cnt <= stretch_cnt - 1'b1;
      end
      tp_stretch <= (stretch_cnt != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_toggle <= 1'b0;
    end else begin
      tp_toggle <= tp_toggle ^ cnt_evt;
    end
  end

  // Clear wins over an event counted in the same cycle; a wrap-cycle
  // event opens the new window rather than closing the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total   <= '0;
      win_cnt <= '0;
      rate    <= '0;
    end else if (clr) begin
      total   <= '0;
      win_cnt <= '0;
      rate    <= '0;
    end else begin
      if (cnt_evt && (total != CNT_MAX)) begin
        total <= total + 1'b1;
      end
      if (snap) begin
        rate    <= win_cnt;
        win_cnt <= cnt_evt ? CNT_ONE : '0;
      end else if (cnt_evt && (win_cnt != CNT_MAX)) begin
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tp_event_monitor.sv
// Test-point event monitor: per-channel debug pulses/toggles plus a shared
// rate window timer, heartbeat and a registered per-channel readout mux.
module tp_event_monitor
  import tp_mon_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int STRETCH = DEF_STRETCH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WIN     = DEF_WIN
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NCH-1:0]            EVT_IN,
  input  logic                      CLR,
  input  logic [idx_width(NCH)-1:0] SEL,
  output logic [NCH-1:0]            TP_STRETCH,
  output logic [NCH-1:0]            TP_TOGGLE,
  output logic                      HEARTBEAT,
  output logic [CNT_W-1:0]          RATE,
  output logic                      RATE_VLD,
  output logic [CNT_W-1:0]          EVT_TOTAL
);

  localparam int            TW       = idx_width(WIN);
  localparam logic [TW-1:0] WIN_LAST = TW'(WIN - 1);

  logic [TW-1:0]    win_timer;
  logic             wrap;
  logic             snap;
  logic             sel_ok;
  logic [CNT_W-1:0] total_arr [NCH];
  logic [CNT_W-1:0] rate_arr  [NCH];

  assign wrap   = (win_timer == WIN_LAST);
  assign snap   = wrap & ~CLR;
  assign sel_ok = (int'(SEL) < NCH);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_timer <= '0;
    end else if (CLR || wrap) begin
      win_timer <= '0;
    end else begin
      win_timer <= win_timer + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RATE_VLD  <= 1'b0;
      HEARTBEAT <= 1'b0;
    end else begin
      RATE_VLD  <= snap;
      HEARTBEAT <= HEARTBEAT ^ snap;
    end
  end

  // Out-of-range selects read as zero when NCH is not a power of two.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RATE      <= '0;
      EVT_TOTAL <= '0;
    end else if (sel_ok) begin
      RATE      <= rate_arr[SEL];
      EVT_TOTAL <= total_arr[SEL];
    end else begin
      RATE      <= '0;
      EVT_TOTAL <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      tp_mon_chan #(
        .STRETCH (STRETCH),
        .CNT_W   (CNT_W)
      ) u_chan (
        .clk        (CLK),
        .rst        (RST),
        .evt_in     (EVT_IN[gi]),
        .clr        (CLR),
        .snap       (snap),
        .tp_stretch (TP_STRETCH[gi]),
        .tp_toggle  (TP_TOGGLE[gi]),
        .total      (total_arr[gi]),
        .rate       (rate_arr[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tp_event_monitor.sv
// Directed bench for tp_event_monitor with STRETCH=4, WIN=10, CNT_W=4, NCH=8.
module tb_tp_event_monitor;

  localparam int NCH     = 8;
  localparam int STRETCH = 4;
  localparam int CNT_W   = 4;
  localparam int WIN     = 10;

  logic             CLK;
  logic             RST;
  logic [NCH-1:0]   EVT_IN;
  logic             CLR;
  logic [2:0]       SEL;
  logic [NCH-1:0]   TP_STRETCH;
  logic [NCH-1:0]   TP_TOGGLE;
  logic             HEARTBEAT;
  logic [CNT_W-1:0] RATE;
  logic             RATE_VLD;
  logic [CNT_W-1:0] EVT_TOTAL;

  int tests = 0;
  int fails = 0;

  tp_event_monitor #(
    .NCH     (NCH),
    .STRETCH (STRETCH),
    .CNT_W   (CNT_W),
    .WIN     (WIN)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EVT_IN     (EVT_IN),
    .CLR        (CLR),
    .SEL        (SEL),
    .TP_STRETCH (TP_STRETCH),
    .TP_TOGGLE  (TP_TOGGLE),
    .HEARTBEAT  (HEARTBEAT),
    .RATE       (RATE),
    .RATE_VLD   (RATE_VLD),
    .EVT_TOTAL  (EVT_TOTAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_stretch"}, 32'(TP_STRETCH), 0);
    check_val({tag, "_toggle"},  32'(TP_TOGGLE),  0);
    check_val({tag, "_hb"},      32'(HEARTBEAT),  0);
    check_val({tag, "_rate"},    32'(RATE),       0);
    check_val({tag, "_rvld"},    32'(RATE_VLD),   0);
    check_val({tag, "_total"},   32'(EVT_TOTAL),  0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST    = 1'b1;
    EVT_IN = '0;
    CLR    = 1'b0;
    SEL    = 3'd0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;

    // Rate windows on ch5, aligned by a CLR pulse; wrap edges at k=10,20,30,40.
    SEL = 3'd5;
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      EVT_IN[5] = (k == 1 || k == 3 || k == 5 || k == 28);
      @(negedge CLK);
      check_val($sformatf("hb_k%0d", k), 32'(HEARTBEAT), (k / 10) % 2);
      if (k % 10 == 0)
        check_val($sformatf("rvld_k%0d", k), 32'(RATE_VLD), 1);
      else if (k % 10 == 9 || k % 10 == 1)
        check_val($sformatf("rvld_k%0d", k), 32'(RATE_VLD), 0);
      case (k)
        11: check_val("rate_win1", 32'(RATE), 3);
        21: check_val("rate_win2", 32'(RATE), 0);
        31: check_val("rate_win3_wrapevt_excluded", 32'(RATE), 0);
        41: begin
          check_val("rate_win4_wrapevt_included", 32'(RATE), 1);
          check_val("total_ch5", 32'(EVT_TOTAL), 4);
        end
        default: ;
      endcase
    end

    // Single strobe on ch2.
    SEL = 3'd2;
    for (int k = 0; k <= 7; k++) begin
      EVT_IN[2] = (k == 0);
      @(negedge CLK);
      check_val($sformatf("ch2_stretch_k%0d", k), 32'(TP_STRETCH[2]), 32'(k >= 2 && k <= 5));
      check_val($sformatf("ch2_toggle_k%0d", k), 32'(TP_TOGGLE[2]), 32'(k >= 2));
      if (k == 2) check_val("ch2_total_early", 32'(EVT_TOTAL), 0);
      if (k == 3) check_val("ch2_total", 32'(EVT_TOTAL), 1);
    end

    // Two strobes on ch0 two cycles apart merge into one 6-cycle pulse.
    SEL = 3'd0;
    for (int k = 0; k <= 9; k++) begin
      EVT_IN[0] = (k == 0 || k == 2);
      @(negedge CLK);
      check_val($sformatf("ch0_stretch_k%0d", k), 32'(TP_STRETCH[0]), 32'(k >= 2 && k <= 7));
      check_val($sformatf("ch0_toggle_k%0d", k), 32'(TP_TOGGLE[0]), 32'(k == 2 || k == 3));
      if (k == 9) check_val("ch0_total", 32'(EVT_TOTAL), 2);
    end

    // 20 events on ch1 saturate the 4-bit total at 15.
    SEL = 3'd1;
    for (int i = 0; i < 20; i++) begin
      EVT_IN[1] = 1'b1;
      @(negedge CLK);
      EVT_IN[1] = 1'b0;
      @(negedge CLK);
    end
    repeat (4) @(negedge CLK);
    check_val("ch1_total_sat", 32'(EVT_TOTAL), 15);

    // CLR held over the cycle in which a new event would be counted.
    EVT_IN[1] = 1'b1;
    CLR = 1'b1;
    repeat (3) @(negedge CLK);
    CLR = 1'b0;
    EVT_IN[1] = 1'b0;
    for (int k = 3; k <= 13; k++) begin
      @(negedge CLK);
      if (k == 5) begin
        check_val("clr_total", 32'(EVT_TOTAL), 0);
        check_val("clr_rate", 32'(RATE), 0);
      end
      if (k == 11) check_val("clr_rvld_before_wrap", 32'(RATE_VLD), 0);
      if (k == 12) check_val("clr_rvld_at_wrap", 32'(RATE_VLD), 1);
      if (k == 13) check_val("clr_rate_after_wrap", 32'(RATE), 0);
    end

    // Async reset mid-stretch with ch3 held high across release.
    SEL = 3'd3;
    EVT_IN[3] = 1'b1;
    repeat (3) @(negedge CLK);
    check_val("ch3_stretch_pre_rst", 32'(TP_STRETCH[3]), 1);
    #2 RST = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge CLK);
    check_all_zero("rst_hold");
    RST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      check_val($sformatf("ch3_stretch_k%0d", k), 32'(TP_STRETCH[3]), 32'(k >= 3 && k <= 6));
      check_val($sformatf("ch3_toggle_k%0d", k), 32'(TP_TOGGLE[3]), 32'(k >= 3));
      if (k == 3) check_val("ch3_total_early", 32'(EVT_TOTAL), 0);
      if (k == 4) check_val("ch3_total", 32'(EVT_TOTAL), 1);
    end
    repeat (5) @(negedge CLK);
    check_val("ch3_total_stuck_high", 32'(EVT_TOTAL), 1);
    EVT_IN[3] = 1'b0;
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
